// File: rtl/lu_update_cell.sv
// lu_update_cell: consumer end of the negation-cell link in the LU systolic array.
// Holds one matrix element, applies STEPS updates a <= a + (x*z >>> FRAC), then
// emits the final value with a one-cycle a_valid pulse. x/z/valid are forwarded
// downstream with one cycle of latency regardless of state.
// Optional feature: define LU_UPDATE_SAT_EN to saturate the update instead of wrapping.
//
// Handshake: in_valid qualifies x_in/z_in (and load) for exactly the cycle it is
// high; there is no backpressure, so every valid beat is either consumed in that
// cycle or only forwarded. The cycle right after the final update is spent in DONE
// and does not consume input.
module lu_update_cell #(
    parameter int SZ    = 8,
    parameter int FRAC  = 4,
    parameter int STEPS = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          load,
    input  logic [SZ-1:0] x_in,
    input  logic [SZ-1:0] z_in,
    output logic [SZ-1:0] x_out,
    output logic [SZ-1:0] z_out,
    output logic          v_out,
    output logic [SZ-1:0] a_out,
    output logic          a_valid,
    output logic          busy,
    output logic [1:0]    dbgState
);

    localparam int CW = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t        stateQ, stateD;
    logic [SZ-1:0] aQ, aD;
    logic [CW-1:0] cntQ, cntD;

    logic signed [2*SZ-1:0] prod;
    logic [SZ:0]            sum;
    logic [SZ-1:0]          upd;

    assign prod = $signed(x_in) * $signed(z_in);

`ifdef LU_UPDATE_SAT_EN
    localparam logic [SZ-1:0] MAXV = {1'b0, {(SZ-1){1'b1}}};
    localparam logic [SZ-1:0] MINV = {1'b1, {(SZ-1){1'b0}}};

    logic signed [2*SZ-1:0] term;
    logic [SZ-1:0]          termSat;

    assign term = prod >>> FRAC;

    // Clamp the shifted product to SZ bits, then add and clamp the sum
    always_comb begin
        termSat = term[SZ-1:0];
        if (!(term[2*SZ-1:SZ-1] == '0 || term[2*SZ-1:SZ-1] == '1)) begin
            termSat = term[2*SZ-1] ? MINV : MAXV;
        end
        sum = {aQ[SZ-1], aQ} + {termSat[SZ-1], termSat};
        upd = sum[SZ-1:0];
        if (sum[SZ] != sum[SZ-1]) begin
            upd = sum[SZ] ? MINV : MAXV;
        end
    end
`else
    // Wrapping add: only the low SZ+1 bits of the shifted product matter
    always_comb begin
        sum = {aQ[SZ-1], aQ} + (SZ+1)'(prod >>> FRAC);
        upd = sum[SZ-1:0];
    end
`endif

    // Next-state, element and step-counter logic
    always_comb begin
        stateD = stateQ;
        aD     = aQ;
        cntD   = cntQ;
        case (stateQ)
            IDLE: begin
                if (in_valid && load) begin
                    aD     = x_in;
                    cntD   = '0;
                    stateD = ACC;
                end
            end
            ACC: begin
                if (in_valid) begin
                    if (load) begin
                        // A new load restarts the element; it wins over an update
                        aD   = x_in;
                        cntD = '0;
                    end else begin
                        aD   = upd;
                        cntD = cntQ + CW'(1);
                        if (cntQ == LAST) begin
                            stateD = DONE;
                        end
                    end
                end
            end
            DONE: begin
                stateD = IDLE;
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    // State, element and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= IDLE;
            aQ     <= '0;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            aQ     <= aD;
            cntQ   <= cntD;
        end
    end

    // Pass-through pipeline to the next cell
    always_ff @(posedge clk) begin
        if (rst) begin
            x_out <= '0;
            z_out <= '0;
            v_out <= 1'b0;
        end else begin
            x_out <= x_in;
            z_out <= z_in;
            v_out <= in_valid;
        end
    end

    // Result register: captured and flagged during the single DONE cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            a_out   <= '0;
            a_valid <= 1'b0;
        end else begin
            a_valid <= (stateQ == DONE);
            if (stateQ == DONE) begin
                a_out <= aQ;
            end
        end
    end

    assign busy     = (stateQ == ACC);
    assign dbgState = stateQ;

endmodule

// File: tb/tb_lu_update_cell.sv
// Bench for lu_update_cell (SZ=8, FRAC=4, STEPS=2): directed scenarios plus a
// randomized run against an element-level reference model.
module tb_lu_update_cell;

    localparam int SZ    = 8;
    localparam int FRAC  = 4;
    localparam int STEPS = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          load = 1'b0;
    logic [SZ-1:0] x_in = '0;
    logic [SZ-1:0] z_in = '0;
    logic [SZ-1:0] x_out, z_out, a_out;
    logic          v_out, a_valid, busy;
    logic [1:0]    dbgState;

    lu_update_cell #(.SZ(SZ), .FRAC(FRAC), .STEPS(STEPS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .load(load),
        .x_in(x_in), .z_in(z_in), .x_out(x_out), .z_out(z_out), .v_out(v_out),
        .a_out(a_out), .a_valid(a_valid), .busy(busy), .dbgState(dbgState)
    );

    // clock
    always #5 clk = ~clk;

    int nChecks = 0;
    int nFail   = 0;

    // reference model: one element in flight, counted in remaining updates
    bit            mActive = 1'b0;
    bit            mFinish = 1'b0;
    int            mA = 0;
    int            mLeft = 0;
    int            mFinal = 0;
    logic [SZ-1:0] mOut = '0;
    logic [SZ-1:0] expX = '0;
    logic [SZ-1:0] expZ = '0;
    bit            expV = 1'b0;
    bit            expPulse = 1'b0;
    logic [SZ-1:0] exp_q[$];
    logic [SZ-1:0] sbExp;

    // element update from plain integer arithmetic
    function automatic int applyUpdate(int a, logic [SZ-1:0] x, logic [SZ-1:0] z);
        int xi, zi, t, s;
        xi = int'($signed(x));
        zi = int'($signed(z));
        t  = (xi * zi) >>> FRAC;
`ifdef LU_UPDATE_SAT_EN
        if (t > 127) t = 127;
        if (t < -128) t = -128;
        s = a + t;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
`else
        s = (a + t) & 255;
        if (s >= 128) s = s - 256;
`endif
        return s;
    endfunction

    // driver: apply one cycle of inputs, advance the model, sample #1 after the edge
    task automatic driveCycle(input bit r, input bit v, input bit l,
                              input logic [SZ-1:0] x, input logic [SZ-1:0] z);
        @(negedge clk);
        rst = r; in_valid = v; load = l; x_in = x; z_in = z;
        @(posedge clk);
        expX = x; expZ = z; expV = v; expPulse = 1'b0;
        if (r) begin
            mActive = 1'b0; mFinish = 1'b0; mA = 0; mLeft = 0; mOut = '0;
            expX = '0; expZ = '0; expV = 1'b0;
        end else if (mFinish) begin
            mFinish  = 1'b0;
            expPulse = 1'b1;
            mOut     = SZ'(mFinal);
            exp_q.push_back(mOut);
        end else if (v && l) begin
            mActive = 1'b1;
            mA      = int'($signed(x));
            mLeft   = STEPS;
        end else if (v && mActive) begin
            mA    = applyUpdate(mA, x, z);
            mLeft = mLeft - 1;
            if (mLeft == 0) begin
                mActive = 1'b0;
                mFinish = 1'b1;
                mFinal  = mA;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) driveCycle(1'b0, 1'b0, 1'b0, SZ'($urandom), SZ'($urandom));
    endtask

    // scoreboard: every a_valid pulse must match the next expected element
    always @(negedge clk) begin
        if (a_valid === 1'b1) begin
            nChecks++;
            if (exp_q.size() == 0) begin
                nFail++;
                $display("FAIL sb_unexpected: a_valid pulse with a_out=%h, none expected", a_out);
            end else begin
                sbExp = exp_q.pop_front();
                if (a_out !== sbExp) begin
                    nFail++;
                    $display("FAIL sb_value: a_out=%h expected %h", a_out, sbExp);
                end
            end
        end
    end

    task automatic test_reset();
        driveCycle(1'b1, 1'b1, 1'($urandom), SZ'($urandom), SZ'($urandom));
        driveCycle(1'b1, 1'b1, 1'($urandom), SZ'($urandom), SZ'($urandom));
        nChecks++; if (x_out !== 8'h00) begin nFail++; $display("FAIL reset_x_out: got %h expected 00", x_out); end
        nChecks++; if (z_out !== 8'h00) begin nFail++; $display("FAIL reset_z_out: got %h expected 00", z_out); end
        nChecks++; if (v_out !== 1'b0) begin nFail++; $display("FAIL reset_v_out: got %b expected 0", v_out); end
        nChecks++; if (a_out !== 8'h00) begin nFail++; $display("FAIL reset_a_out: got %h expected 00", a_out); end
        nChecks++; if (a_valid !== 1'b0) begin nFail++; $display("FAIL reset_a_valid: got %b expected 0", a_valid); end
        nChecks++; if (busy !== 1'b0) begin nFail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_forward();
        driveCycle(1'b0, 1'b1, 1'b0, 8'h5A, 8'hA6);
        nChecks++; if (x_out !== 8'h5A) begin nFail++; $display("FAIL fwd_x_out: got %h expected 5a", x_out); end
        nChecks++; if (z_out !== 8'hA6) begin nFail++; $display("FAIL fwd_z_out: got %h expected a6", z_out); end
        nChecks++; if (v_out !== 1'b1) begin nFail++; $display("FAIL fwd_v_out: got %b expected 1", v_out); end
        nChecks++; if (busy !== 1'b0) begin nFail++; $display("FAIL fwd_busy: got %b expected 0", busy); end
    endtask

    task automatic test_normal();
        driveCycle(1'b0, 1'b1, 1'b1, 8'd32, 8'h00);
        nChecks++; if (busy !== 1'b1) begin nFail++; $display("FAIL normal_busy_load: got %b expected 1", busy); end
        driveCycle(1'b0, 1'b1, 1'b0, 8'd16, 8'hF8);
        nChecks++; if (busy !== 1'b1) begin nFail++; $display("FAIL normal_busy_upd1: got %b expected 1", busy); end
        driveCycle(1'b0, 1'b1, 1'b0, 8'd32, 8'hF0);
        nChecks++; if (busy !== 1'b0) begin nFail++; $display("FAIL normal_busy_upd2: got %b expected 0", busy); end
        nChecks++; if (a_valid !== 1'b0) begin nFail++; $display("FAIL normal_early_pulse: got %b expected 0", a_valid); end
        idle(1);
        nChecks++; if (a_valid !== 1'b1) begin nFail++; $display("FAIL normal_pulse: got %b expected 1", a_valid); end
        nChecks++; if (a_out !== 8'hF8) begin nFail++; $display("FAIL normal_a_out: got %h expected f8", a_out); end
        idle(1);
        nChecks++; if (a_valid !== 1'b0) begin nFail++; $display("FAIL normal_pulse_width: got %b expected 0", a_valid); end
        nChecks++; if (a_out !== 8'hF8) begin nFail++; $display("FAIL normal_a_out_hold: got %h expected f8", a_out); end
    endtask

    task automatic test_overflow();
        logic [SZ-1:0] want;
`ifdef LU_UPDATE_SAT_EN
        want = 8'h7F;
`else
        want = 8'hF7;
`endif
        driveCycle(1'b0, 1'b1, 1'b1, 8'd120, 8'h00);
        driveCycle(1'b0, 1'b1, 1'b0, 8'd127, 8'd16);
        driveCycle(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        idle(1);
        nChecks++; if (a_valid !== 1'b1) begin nFail++; $display("FAIL ovf_pulse: got %b expected 1", a_valid); end
        nChecks++; if (a_out !== want) begin nFail++; $display("FAIL ovf_a_out: got %h expected %h", a_out, want); end
        idle(1);
    endtask

    task automatic test_restart_gaps();
        int pulses;
        pulses = 0;
        driveCycle(1'b0, 1'b1, 1'b1, 8'd32, 8'h00);  pulses += int'(a_valid);
        driveCycle(1'b0, 1'b1, 1'b0, 8'd16, 8'hF8);  pulses += int'(a_valid);
        for (int i = 0; i < 3; i++) begin
            idle(1); pulses += int'(a_valid);
            nChecks++; if (busy !== 1'b1) begin nFail++; $display("FAIL gap_busy: got %b expected 1", busy); end
        end
        driveCycle(1'b0, 1'b1, 1'b1, 8'd16, 8'h00);  pulses += int'(a_valid);
        driveCycle(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);    pulses += int'(a_valid);
        nChecks++; if (busy !== 1'b1) begin nFail++; $display("FAIL restart_busy: got %b expected 1", busy); end
        driveCycle(1'b0, 1'b1, 1'b0, 8'd16, 8'd16);  pulses += int'(a_valid);
        idle(1);                                     pulses += int'(a_valid);
        nChecks++; if (a_out !== 8'h20) begin nFail++; $display("FAIL restart_a_out: got %h expected 20", a_out); end
        idle(1);                                     pulses += int'(a_valid);
        nChecks++; if (pulses != 1) begin nFail++; $display("FAIL restart_pulses: got %0d expected 1", pulses); end
    endtask

    task automatic test_reset_mid();
        driveCycle(1'b0, 1'b1, 1'b1, 8'd32, 8'h00);
        driveCycle(1'b0, 1'b1, 1'b0, 8'd16, 8'hF8);
        driveCycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        nChecks++; if (busy !== 1'b0) begin nFail++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        nChecks++; if (a_out !== 8'h00) begin nFail++; $display("FAIL rmid_a_out: got %h expected 00", a_out); end
        for (int i = 0; i < 2; i++) begin
            idle(1);
            nChecks++; if (a_valid !== 1'b0) begin nFail++; $display("FAIL rmid_no_pulse: got %b expected 0", a_valid); end
        end
        driveCycle(1'b0, 1'b1, 1'b1, 8'd32, 8'h00);
        driveCycle(1'b0, 1'b1, 1'b0, 8'd16, 8'hF8);
        driveCycle(1'b0, 1'b1, 1'b0, 8'd32, 8'hF0);
        idle(1);
        nChecks++; if (a_valid !== 1'b1) begin nFail++; $display("FAIL rmid_pulse: got %b expected 1", a_valid); end
        nChecks++; if (a_out !== 8'hF8) begin nFail++; $display("FAIL rmid_a_out_after: got %h expected f8", a_out); end
    endtask

    task automatic test_random();
        bit r, v, l;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 49) == 0);
            v = ($urandom_range(0, 9) < 7);
            l = v && ($urandom_range(0, 3) == 0);
            driveCycle(r, v, l, SZ'($urandom), SZ'($urandom));
            nChecks++; if (x_out !== expX) begin nFail++; $display("FAIL rand_x_out: cycle %0d got %h expected %h", i, x_out, expX); end
            nChecks++; if (z_out !== expZ) begin nFail++; $display("FAIL rand_z_out: cycle %0d got %h expected %h", i, z_out, expZ); end
            nChecks++; if (v_out !== expV) begin nFail++; $display("FAIL rand_v_out: cycle %0d got %b expected %b", i, v_out, expV); end
            nChecks++; if (a_valid !== expPulse) begin nFail++; $display("FAIL rand_a_valid: cycle %0d got %b expected %b", i, a_valid, expPulse); end
            nChecks++; if (a_out !== mOut) begin nFail++; $display("FAIL rand_a_out: cycle %0d got %h expected %h", i, a_out, mOut); end
            nChecks++; if (busy !== mActive) begin nFail++; $display("FAIL rand_busy: cycle %0d got %b expected %b", i, busy, mActive); end
        end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_forward();
        test_normal();
        test_overflow();
        test_restart_gaps();
        test_reset_mid();
        test_random();
        idle(2);
        nChecks++;
        if (exp_q.size() != 0) begin
            nFail++;
            $display("FAIL sb_drain: %0d expected results never pulsed, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
